// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Decode-stage pipeline hazard controller. Detects load-use hazards,
//   data-memory busy stalls, instruction-fetch misses and taken branches, and
//   produces per-stage stall/flush strobes. A small registered FSM tracks
//   multi-cycle stall episodes and runs a memory-wait watchdog.
//
//   Optional build macro: HAZARD_STATS_EN adds saturating statistics counters
//   (lu_count, mem_wait_count, flush_count).
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   id_rs1/id_rs2 source registers of the instruction in decode
//   id_uses_rs2   decode instruction actually reads rs2
//   ex_memread    instruction in EX is a load
//   ex_rd         destination register of the instruction in EX
//   branch_taken  M stage resolved a taken branch/jump this cycle
//   mem_busy      data memory not ready
//   fetch_busy    instruction memory not ready
//   stall_fetch   hold PC
//   stall_decode  hold IF/ID; also injects a bubble into EX
//   stall_exec    hold ID/EX and EX/M
//   flush_decode  zero IF/ID at the next edge
//   flush_exec    zero ID/EX at the next edge
//   mem_timeout   sticky watchdog flag (cleared only by reset)
//   lu_count, mem_wait_count, flush_count  statistics (HAZARD_STATS_EN only)
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  input  logic                  fetch_busy,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  stall_exec,
  output logic                  flush_decode,
  output logic                  flush_exec,
  output logic                  mem_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]      lu_count,
  output logic [CNT_W-1:0]      mem_wait_count,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state;
  state_t          next_state;
  logic [WD_W-1:0] wd_cnt;
  logic            load_use;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // Outputs are zero-latency: they depend on the current state and inputs.
  // NOTE: every output and next_state gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    stall_exec   = 1'b0;
    flush_decode = 1'b0;
    flush_exec   = 1'b0;
    next_state   = RUN;
    if (!reset) begin
      if (mem_busy) begin
        stall_fetch  = 1'b1;
        stall_decode = 1'b1;
        stall_exec   = 1'b1;
        next_state   = MEM_WAIT;
      end else if (branch_taken) begin
        // A redirect kills whatever is in IF/ID and ID/EX, including any
        // instruction that would otherwise be stalled on a load.
        flush_decode = 1'b1;
        flush_exec   = 1'b1;
      end else begin
        case (state)
          // The exit cycle of MEM_WAIT behaves exactly like RUN.
          RUN, MEM_WAIT: begin
            if (load_use) begin
              stall_fetch  = 1'b1;
              stall_decode = 1'b1;
              next_state   = LU_STALL;
            end else if (fetch_busy) begin
              stall_fetch  = 1'b1;
              flush_decode = 1'b1;
            end
          end
          // One bubble is already in EX; release the pipe this cycle.
          LU_STALL: next_state = RUN;
          default:  next_state = RUN;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wd_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= next_state;
      // Count only while the wait episode continues; leaving MEM_WAIT clears.
      if ((state == MEM_WAIT) && (next_state == MEM_WAIT)) begin
        if (wd_cnt != WD_W'(MEM_TIMEOUT))
          wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      // Fires on the edge where the count reaches MEM_TIMEOUT with memory
      // still busy; sticky until reset.
      if ((state == MEM_WAIT) && mem_busy && (wd_cnt >= WD_W'(MEM_TIMEOUT - 1)))
        mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic lu_cycle;
  logic flush_cycle;

  // stall_decode without stall_exec is produced only by a load-use stall;
  // flush_exec is produced only by a taken branch.
  assign lu_cycle    = stall_decode && !stall_exec;
  assign flush_cycle = flush_exec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lu_count       <= '0;
      mem_wait_count <= '0;
      flush_count    <= '0;
    end else begin
      if (lu_cycle && !(&lu_count))
        lu_count <= lu_count + 1'b1;
      if ((state == MEM_WAIT) && !(&mem_wait_count))
        mem_wait_count <= mem_wait_count + 1'b1;
      if (flush_cycle && !(&flush_count))
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//   Self-checking bench for hazard_unit (MEM_TIMEOUT = 4). Each stimulus cycle
//   pushes its expected output vector onto a scoreboard queue; the vector is
//   popped and compared on the following falling edge.
//   Output vector order: {stall_fetch, stall_decode, stall_exec,
//                         flush_decode, flush_exec, mem_timeout}
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs2, ex_memread, branch_taken, mem_busy, fetch_busy;
  logic          stall_fetch, stall_decode, stall_exec;
  logic          flush_decode, flush_exec, mem_timeout;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] lu_count, mem_wait_count, flush_count;
`endif

  always #5 clk = ~clk;

  hazard_unit #(
    .REG_ADDR_W  (AW),
    .MEM_TIMEOUT (4),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs2  (id_uses_rs2),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .fetch_busy   (fetch_busy),
    .stall_fetch  (stall_fetch),
    .stall_decode (stall_decode),
    .stall_exec   (stall_exec),
    .flush_decode (flush_decode),
    .flush_exec   (flush_exec),
    .mem_timeout  (mem_timeout)
`ifdef HAZARD_STATS_EN
    ,
    .lu_count       (lu_count),
    .mem_wait_count (mem_wait_count),
    .flush_count    (flush_count)
`endif
  );

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [5:0] outs();
    return {stall_fetch, stall_decode, stall_exec, flush_decode, flush_exec, mem_timeout};
  endfunction

  // Called just after a rising edge: applies one cycle of stimulus, records
  // the expectation, compares on the falling edge, returns after the next
  // rising edge.
  task automatic drive(input string tag,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic u2, input logic mr, input logic [AW-1:0] rd,
                       input logic br, input logic mb, input logic fb,
                       input logic [5:0] exp);
    exp_t e;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_uses_rs2  = u2;
    ex_memread   = mr;
    ex_rd        = rd;
    branch_taken = br;
    mem_busy     = mb;
    fetch_busy   = fb;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check(e.tag, 32'(outs()), 32'(e.exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    id_rs1       = '0;
    id_rs2       = '0;
    id_uses_rs2  = 1'b0;
    ex_memread   = 1'b0;
    ex_rd        = '0;
    branch_taken = 1'b1;
    mem_busy     = 1'b1;
    fetch_busy   = 1'b1;
    #3;
    check("reset_gates_outputs", 32'(outs()), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Load-use on rs1: exactly one stall cycle, then released.
    drive("lu_rs1",       5, 0, 0, 1, 5, 0, 0, 0, 6'b110000);
    drive("lu_hold",      5, 0, 0, 1, 5, 0, 0, 0, 6'b000000);
    drive("lu_bubble",    5, 0, 0, 0, 5, 0, 0, 0, 6'b000000);
    drive("lu_rd_zero",   0, 0, 0, 1, 0, 0, 0, 0, 6'b000000);
    // rs2 match only matters when rs2 is used.
    drive("rs2_unused",   0, 7, 0, 1, 7, 0, 0, 0, 6'b000000);
    drive("rs2_used",     0, 7, 1, 1, 7, 0, 0, 0, 6'b110000);
    drive("rs2_release",  0, 7, 1, 0, 7, 0, 0, 0, 6'b000000);
    // Branch beats load-use and fetch miss.
    drive("br_priority",  5, 0, 0, 1, 5, 1, 0, 1, 6'b000110);
    drive("fetch_only",   0, 0, 0, 0, 0, 0, 0, 1, 6'b100100);
    // mem_busy beats branch; branch honoured on the MEM_WAIT exit cycle.
    drive("mb_over_br",   0, 0, 0, 0, 0, 1, 1, 0, 6'b111000);
    drive("br_after_mb",  0, 0, 0, 0, 0, 1, 0, 0, 6'b000110);
    // mem_busy beats load-use; load-use evaluated on the exit cycle.
    drive("mb_over_lu",   5, 0, 0, 1, 5, 0, 1, 0, 6'b111000);
    drive("exit_lu",      5, 0, 0, 1, 5, 0, 0, 0, 6'b110000);
    drive("exit_lu_rel",  5, 0, 0, 0, 5, 0, 0, 0, 6'b000000);

    // Ten busy cycles; watchdog (timeout 4) fires visibly from cycle 6.
    for (int i = 1; i <= 10; i++)
      drive($sformatf("mw_busy_%0d", i), 0, 0, 0, 0, 0, 0, 1, 0,
            (i >= 6) ? 6'b111001 : 6'b111000);
    // Asynchronous reset between edges, mem_busy still high.
    #2 reset = 1'b1;
    #1 check("async_reset_outs", 32'(outs()), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive("post_rst_lu",  5, 0, 0, 1, 5, 0, 0, 0, 6'b110000);
    drive("post_rst_idle",0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);

    // Watchdog: six busy cycles, flag rises on the sixth and stays set.
    for (int i = 1; i <= 6; i++)
      drive($sformatf("wd_busy_%0d", i), 0, 0, 0, 0, 0, 0, 1, 0,
            (i == 6) ? 6'b111001 : 6'b111000);
    drive("wd_release",   0, 0, 0, 0, 0, 0, 0, 0, 6'b000001);
    drive("wd_sticky",    0, 0, 0, 0, 0, 0, 0, 0, 6'b000001);

`ifdef HAZARD_STATS_EN
    check("mem_wait_count", 32'(mem_wait_count), 32'd6);
    check("lu_count",       32'(lu_count),       32'd1);
    check("flush_count",    32'(flush_count),    32'd0);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
